// File: rtl/bus_arb_pkg.sv
// Shared types and sizes for the 4-source round-robin bus arbiter.
package bus_arb_pkg;

  localparam int NREQ  = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return {{(NREQ-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority search: first set request at or above ptr, wrapping 3 -> 0.
module rr_pick4
  import bus_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] w_cand;
  logic [SEL_W-1:0] w_idx;

  // Walk from the farthest candidate back to ptr so the nearest hit wins.
  always_comb begin
    w_idx  = ptr;
    w_cand = ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_cand = ptr + SEL_W'(k);
      if (req[w_cand]) w_idx = w_cand;
    end
  end

  assign any = |req;
  assign idx = w_idx;

endmodule

// File: rtl/bus_arb4.sv
// Four-source round-robin bus arbiter with hold limit and one dead cycle between owners.
//
// state   | meaning
// IDLE    | no owner; arbitrate among requests starting at ptr
// GRANT   | owner sel holds the bus; cnt counts cycles held
// RELEASE | bus dropped for one cycle; ptr advances past last owner
module bus_arb4
  import bus_arb_pkg::*;
#(
  parameter int HOLD_MAX = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic             done,
  output logic [NREQ-1:0]  gnt,
  output logic [SEL_W-1:0] sel,
  output logic             bus_en,
  output logic             timeout
);

  localparam int               CNT_W    = $clog2(HOLD_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

  state_t           r_state;
  logic [NREQ-1:0]  r_gnt;
  logic [SEL_W-1:0] r_sel;
  logic             r_bus_en;
  logic             r_timeout;
  logic [SEL_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_cnt;

  state_t           w_state_nxt;
  logic [NREQ-1:0]  w_gnt_nxt;
  logic [SEL_W-1:0] w_sel_nxt;
  logic             w_bus_en_nxt;
  logic             w_timeout_nxt;
  logic [SEL_W-1:0] w_ptr_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic             w_any;
  logic [SEL_W-1:0] w_idx;
  logic             w_req_own;
  logic             w_at_max;

  rr_pick4 u_pick (
    .req (req),
    .ptr (r_ptr),
    .any (w_any),
    .idx (w_idx)
  );

  assign w_req_own = req[r_sel];
  assign w_at_max  = (r_cnt == CNT_LAST);

  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_sel_nxt     = r_sel;
    w_bus_en_nxt  = r_bus_en;
    w_timeout_nxt = 1'b0;
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt  = GRANT;
          w_gnt_nxt    = onehot(w_idx);
          w_sel_nxt    = w_idx;
          w_bus_en_nxt = 1'b1;
          w_cnt_nxt    = '0;
        end
      end
      GRANT: begin
        if (done || !w_req_own || w_at_max) begin
          // done wins over the hold limit, so a completing owner never flags timeout
          w_state_nxt   = RELEASE;
          w_gnt_nxt     = '0;
          w_bus_en_nxt  = 1'b0;
          w_timeout_nxt = w_at_max && !done && w_req_own;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      RELEASE: begin
        w_state_nxt = IDLE;
        w_ptr_nxt   = r_sel + 1'b1;
      end
      default: begin
        w_state_nxt  = IDLE;
        w_gnt_nxt    = '0;
        w_bus_en_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_sel     <= '0;
      r_bus_en  <= 1'b0;
      r_timeout <= 1'b0;
      r_ptr     <= '0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_sel     <= w_sel_nxt;
      r_bus_en  <= w_bus_en_nxt;
      r_timeout <= w_timeout_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  assign gnt     = r_gnt;
  assign sel     = r_sel;
  assign bus_en  = r_bus_en;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_bus_arb4.sv
// Self-checking bench for bus_arb4: directed vector table, hand sequences, random vs. model.
module tb_bus_arb4;

  localparam int HOLD = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] req   = 4'd0;
  logic       done  = 1'b0;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       bus_en;
  logic       timeout;

  int n_chk  = 0;
  int n_fail = 0;

  bus_arb4 #(.HOLD_MAX(HOLD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .sel     (sel),
    .bus_en  (bus_en),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the bus, how long it has held it, and a cool-down flag.
  int m_owner;
  int m_held;
  int m_ptr;
  int m_last;
  bit m_gap;
  bit m_to;

  function automatic void model_reset();
    m_owner = -1;
    m_held  = 0;
    m_ptr   = 0;
    m_last  = 0;
    m_gap   = 1'b0;
    m_to    = 1'b0;
  endfunction

  function automatic void model_step(input logic [3:0] r, input logic d);
    m_to = 1'b0;
    if (m_owner >= 0) begin
      m_held++;
      if (d || !r[m_owner] || m_held == HOLD) begin
        m_to    = !d && r[m_owner] && (m_held == HOLD);
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
        m_gap   = 1'b1;
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if (r != 4'd0) begin
      for (int k = 0; k < 4; k++)
        if (m_owner < 0 && r[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
      m_last = m_owner;
      m_held = 0;
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [3:0] eg;
    eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0;
    chk("model gnt", 32'(gnt), 32'(eg));
    chk("model sel", 32'(sel), 32'(m_last));
    chk("model bus_en", 32'(bus_en), 32'(m_owner >= 0));
    chk("model timeout", 32'(timeout), 32'(m_to));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(req, done);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct packed {
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       en;
    logic       to;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] r, input logic d, input logic [3:0] g,
                     input logic [1:0] s, input logic e, input logic t);
    vec_t x;
    x.req  = r;
    x.done = d;
    x.gnt  = g;
    x.sel  = s;
    x.en   = e;
    x.to   = t;
    tbl.push_back(x);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // single request, done ends it, ptr moves past owner 2
    add(4'b0100, 0, 4'b0100, 2'd2, 1, 0);
    add(4'b0100, 0, 4'b0100, 2'd2, 1, 0);
    add(4'b0100, 0, 4'b0100, 2'd2, 1, 0);
    add(4'b0100, 1, 4'b0000, 2'd2, 0, 0);
    add(4'b0000, 0, 4'b0000, 2'd2, 0, 0);
    // all requesting, done every grant cycle: rotation 3,0,1,2
    add(4'b1111, 1, 4'b1000, 2'd3, 1, 0);
    add(4'b1111, 1, 4'b0000, 2'd3, 0, 0);
    add(4'b1111, 1, 4'b0000, 2'd3, 0, 0);
    add(4'b1111, 1, 4'b0001, 2'd0, 1, 0);
    add(4'b1111, 1, 4'b0000, 2'd0, 0, 0);
    add(4'b1111, 1, 4'b0000, 2'd0, 0, 0);
    add(4'b1111, 1, 4'b0010, 2'd1, 1, 0);
    add(4'b1111, 1, 4'b0000, 2'd1, 0, 0);
    add(4'b1111, 1, 4'b0000, 2'd1, 0, 0);
    add(4'b1111, 1, 4'b0100, 2'd2, 1, 0);
    add(4'b1111, 1, 4'b0000, 2'd2, 0, 0);
    add(4'b1111, 1, 4'b0000, 2'd2, 0, 0);
    // hold limit: four grant cycles, timeout pulse, re-grant
    add(4'b0001, 0, 4'b0001, 2'd0, 1, 0);
    add(4'b0001, 0, 4'b0001, 2'd0, 1, 0);
    add(4'b0001, 0, 4'b0001, 2'd0, 1, 0);
    add(4'b0001, 0, 4'b0001, 2'd0, 1, 0);
    add(4'b0001, 0, 4'b0000, 2'd0, 0, 1);
    add(4'b0001, 0, 4'b0000, 2'd0, 0, 0);
    add(4'b0001, 0, 4'b0001, 2'd0, 1, 0);
    add(4'b0001, 1, 4'b0000, 2'd0, 0, 0);
    add(4'b0000, 0, 4'b0000, 2'd0, 0, 0);
    // done in the last allowed cycle suppresses timeout
    add(4'b0001, 0, 4'b0001, 2'd0, 1, 0);
    add(4'b0001, 0, 4'b0001, 2'd0, 1, 0);
    add(4'b0001, 0, 4'b0001, 2'd0, 1, 0);
    add(4'b0001, 0, 4'b0001, 2'd0, 1, 0);
    add(4'b0001, 1, 4'b0000, 2'd0, 0, 0);
    add(4'b0000, 0, 4'b0000, 2'd0, 0, 0);

    model_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("reset gnt", 32'(gnt), 32'h0);
    chk("reset sel", 32'(sel), 32'h0);
    chk("reset bus_en", 32'(bus_en), 32'h0);
    chk("reset timeout", 32'(timeout), 32'h0);
    do_reset();

    foreach (tbl[i]) begin
      req  = tbl[i].req;
      done = tbl[i].done;
      cycle();
      chk($sformatf("tbl[%0d].gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      chk($sformatf("tbl[%0d].sel", i), 32'(sel), 32'(tbl[i].sel));
      chk($sformatf("tbl[%0d].bus_en", i), 32'(bus_en), 32'(tbl[i].en));
      chk($sformatf("tbl[%0d].timeout", i), 32'(timeout), 32'(tbl[i].to));
      check_model();
    end

    // owner 1 drops its request in its third grant cycle; source 3 follows
    req = 4'b0000; done = 1'b0;
    do_reset();
    req = 4'b1010;
    cycle();
    chk("drop grant1 gnt", 32'(gnt), 32'h2);
    chk("drop grant1 sel", 32'(sel), 32'h1);
    cycle();
    cycle();
    req = 4'b1000;
    cycle();
    chk("drop release bus_en", 32'(bus_en), 32'h0);
    chk("drop release timeout", 32'(timeout), 32'h0);
    cycle();
    chk("drop idle bus_en", 32'(bus_en), 32'h0);
    chk("drop idle timeout", 32'(timeout), 32'h0);
    cycle();
    chk("drop grant3 gnt", 32'(gnt), 32'h8);
    chk("drop grant3 sel", 32'(sel), 32'h3);
    check_model();
    req = 4'b0000;
    repeat (3) begin
      cycle();
      check_model();
    end

    // asynchronous reset while source 2 owns the bus
    do_reset();
    req = 4'b0100;
    cycle();
    chk("rst grant gnt", 32'(gnt), 32'h4);
    chk("rst grant sel", 32'(sel), 32'h2);
    cycle();
    #2 rst_n = 1'b0;
    #1;
    chk("async rst gnt", 32'(gnt), 32'h0);
    chk("async rst sel", 32'(sel), 32'h0);
    chk("async rst bus_en", 32'(bus_en), 32'h0);
    model_reset();
    req = 4'b0101;
    @(posedge clk);
    @(negedge clk);
    chk("in rst timeout", 32'(timeout), 32'h0);
    chk("in rst bus_en", 32'(bus_en), 32'h0);
    rst_n = 1'b1;
    cycle();
    chk("post rst gnt", 32'(gnt), 32'h1);
    chk("post rst sel", 32'(sel), 32'h0);
    check_model();

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) req = 4'($urandom);
      done = ($urandom_range(7) == 0);
      cycle();
      check_model();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
